key_conditioner: RTL and testbench

- Input conditioning stage between the board push-buttons (active-low KEYn pins) and the stopwatch timer.
- Per key:
  - synchronises the asynchronous pin into clk;
  - rejects contact bounce with a time-based debounce filter;
  - emits clean single-cycle press, release and long-press pulses plus a debounced level.
- The timer consumes key_press as its start/stop and reset strobes and key_long as a hard clear, so it needs no edge-detect logic of its own.

---
 rtl/key_conditioner.sv | 173 +++++++++++++++++
 tb/tb_key_conditioner.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_conditioner.sv
// key_conditioner: push-button front end for the stopwatch timer.
//
// Each active-low key pin is synchronised into clk, debounced by requiring
// a stable level for DB_CYC consecutive cycles, and turned into a debounced
// level plus single-cycle press / release / long-press pulses.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   key_n        raw buttons, active-low, asynchronous to clk
//   key_level    debounced state, 1 = held
//   key_press    1-cycle pulse on accepted press
//   key_release  1-cycle pulse on accepted release
//   key_long     1-cycle pulse once per press after LONG_CYC held
//
// Per-key FSM:
//   state       | meaning
//   RELEASED    | key idle, waiting for the pin to go low
//   PRESS_CHK   | pin low, counting stable cycles before accepting the press
//   PRESSED     | press accepted, counting hold time towards a long press
//   RELEASE_CHK | pin high, counting stable cycles before accepting release

module key_conditioner #(
    parameter int FREQ_MHZ    = 50,
    parameter int DEBOUNCE_MS = 10,
    parameter int LONG_MS     = 1000,
    parameter int NUM_KEYS    = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_long
);

    localparam int DB_CYC   = FREQ_MHZ * 1000 * DEBOUNCE_MS;
    localparam int LONG_CYC = FREQ_MHZ * 1000 * LONG_MS;
    localparam int DW       = $clog2(DB_CYC);
    localparam int LW       = $clog2(LONG_CYC);

    localparam logic [DW-1:0] DB_LAST   = DW'(DB_CYC - 1);
    localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYC - 1);

    typedef enum logic [1:0] {
        RELEASED    = 2'd0,
        PRESS_CHK   = 2'd1,
        PRESSED     = 2'd2,
        RELEASE_CHK = 2'd3
    } state_t;

    logic [NUM_KEYS-1:0] sync1_q, sync1_d;
    logic [NUM_KEYS-1:0] sync2_q, sync2_d;

    state_t              state_q [NUM_KEYS];
    state_t              state_d [NUM_KEYS];
    logic [DW-1:0]       dcnt_q  [NUM_KEYS];
    logic [DW-1:0]       dcnt_d  [NUM_KEYS];
    logic [LW-1:0]       lcnt_q  [NUM_KEYS];
    logic [LW-1:0]       lcnt_d  [NUM_KEYS];

    // Set once the long pulse has fired, so a saturated lcnt cannot repeat it.
    logic [NUM_KEYS-1:0] long_done_q, long_done_d;

    logic [NUM_KEYS-1:0] level_q, level_d;
    logic [NUM_KEYS-1:0] press_q, press_d;
    logic [NUM_KEYS-1:0] release_q, release_d;
    logic [NUM_KEYS-1:0] long_q, long_d;

    always_comb begin
        sync1_d     = key_n;
        sync2_d     = sync1_q;
        long_done_d = long_done_q;
        level_d     = '0;
        press_d     = '0;
        release_d   = '0;
        long_d      = '0;

        for (int i = 0; i < NUM_KEYS; i++) begin
            state_d[i] = state_q[i];
            dcnt_d[i]  = dcnt_q[i];
            lcnt_d[i]  = lcnt_q[i];

            case (state_q[i])
                RELEASED: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = PRESS_CHK;
                        dcnt_d[i]  = '0;
                    end
                end
                PRESS_CHK: begin
                    if (sync2_q[i]) begin
                        state_d[i] = RELEASED;
                    end else if (dcnt_q[i] == DB_LAST) begin
                        state_d[i]     = PRESSED;
                        press_d[i]     = 1'b1;
                        lcnt_d[i]      = '0;
                        long_done_d[i] = 1'b0;
                    end else begin
                        dcnt_d[i] = dcnt_q[i] + 1'b1;
                    end
                end
                PRESSED: begin
                    if (sync2_q[i]) begin
                        state_d[i] = RELEASE_CHK;
                        dcnt_d[i]  = '0;
                    end else if (!long_done_q[i]) begin
                        if (lcnt_q[i] == LONG_LAST) begin
                            long_d[i]      = 1'b1;
                            long_done_d[i] = 1'b1;
                        end else begin
                            lcnt_d[i] = lcnt_q[i] + 1'b1;
                        end
                    end
                end
                RELEASE_CHK: begin
                    // A short high glitch returns to PRESSED with the hold
                    // time intact, so the long press is only delayed.
                    if (!sync2_q[i]) begin
                        state_d[i] = PRESSED;
                    end else if (dcnt_q[i] == DB_LAST) begin
                        state_d[i]   = RELEASED;
                        release_d[i] = 1'b1;
                    end else begin
                        dcnt_d[i] = dcnt_q[i] + 1'b1;
                    end
                end
                default: begin
                    state_d[i] = RELEASED;
                end
            endcase

            level_d[i] = (state_d[i] == PRESSED) || (state_d[i] == RELEASE_CHK);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= '1;
            sync2_q     <= '1;
            long_done_q <= '0;
            level_q     <= '0;
            press_q     <= '0;
            release_q   <= '0;
            long_q      <= '0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                state_q[i] <= RELEASED;
                dcnt_q[i]  <= '0;
                lcnt_q[i]  <= '0;
            end
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            long_done_q <= long_done_d;
            level_q     <= level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
            for (int i = 0; i < NUM_KEYS; i++) begin
                state_q[i] <= state_d[i];
                dcnt_q[i]  <= dcnt_d[i];
                lcnt_q[i]  <= lcnt_d[i];
            end
        end
    end

    assign key_level   = level_q;
    assign key_press   = press_q;
    assign key_release = release_q;
    assign key_long    = long_q;

endmodule

// File: tb/tb_key_conditioner.sv
module tb_key_conditioner;

    localparam int DB_CYC   = 1000;
    localparam int LONG_CYC = 5000;

    logic       clk;
    logic       rst_n;
    logic [1:0] key_n;
    logic [1:0] key_level, key_press, key_release, key_long;

    key_conditioner #(
        .FREQ_MHZ    (1),
        .DEBOUNCE_MS (1),
        .LONG_MS     (5),
        .NUM_KEYS    (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_n       (key_n),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_long    (key_long)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- behavioural reference model ----------------
    // Run-length view: a key's debounced level flips once the synchronised
    // pin has disagreed with it for DB_CYC+1 consecutive edges. Hold time
    // advances only on edges where the pin agrees and no disagreement run
    // was in progress.
    logic [1:0] hist[$];
    int         run  [2];
    bit         lvl  [2];
    int         held [2];
    bit         fired[2];
    logic [1:0] m_level, m_press, m_rel, m_long;

    task automatic model_reset();
        hist.delete();
        hist.push_back(2'b11);
        hist.push_back(2'b11);
        for (int k = 0; k < 2; k++) begin
            run[k] = 0; lvl[k] = 0; held[k] = 0; fired[k] = 0;
        end
        m_level = '0; m_press = '0; m_rel = '0; m_long = '0;
    endtask

    task automatic model_step();
        logic [1:0] s;
        bit want, quiet;
        hist.push_back(key_n);
        s = hist.pop_front();
        m_press = '0; m_rel = '0; m_long = '0;
        for (int k = 0; k < 2; k++) begin
            want  = !s[k];
            quiet = (run[k] == 0);
            if (want != lvl[k]) begin
                run[k]++;
                if (run[k] == DB_CYC + 1) begin
                    lvl[k] = want;
                    run[k] = 0;
                    if (want) begin
                        m_press[k] = 1'b1; held[k] = 0; fired[k] = 0;
                    end else begin
                        m_rel[k] = 1'b1;
                    end
                end
            end else begin
                if (lvl[k] && quiet) begin
                    held[k]++;
                    if (held[k] == LONG_CYC && !fired[k]) begin
                        m_long[k] = 1'b1; fired[k] = 1;
                    end
                end
                run[k] = 0;
            end
            m_level[k] = lvl[k];
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step(); else model_reset();
        @(negedge clk);
        total++;
        if ({key_level, key_press, key_release, key_long} !== {m_level, m_press, m_rel, m_long}) begin
            bad++;
            $display("FAIL cycle_model t=%0t got lvl=%b pr=%b rl=%b lg=%b exp lvl=%b pr=%b rl=%b lg=%b",
                     $time, key_level, key_press, key_release, key_long,
                     m_level, m_press, m_rel, m_long);
        end
    endtask

    int         edge_no;
    int         n_press[2], n_rel[2], n_long[2], n_rise[2], n_fall[2];
    int         e_press[2], e_rel[2], e_long[2], e_rise[2], e_fall[2];
    logic [1:0] prev_lvl;

    task automatic clear_watch();
        edge_no = 0;
        for (int k = 0; k < 2; k++) begin
            n_press[k] = 0; n_rel[k] = 0; n_long[k] = 0; n_rise[k] = 0; n_fall[k] = 0;
            e_press[k] = -1; e_rel[k] = -1; e_long[k] = -1; e_rise[k] = -1; e_fall[k] = -1;
        end
        prev_lvl = key_level;
    endtask

    task automatic watch(input int n);
        for (int c = 0; c < n; c++) begin
            tick();
            edge_no++;
            for (int k = 0; k < 2; k++) begin
                if (key_press[k])   begin n_press[k]++; if (e_press[k] < 0) e_press[k] = edge_no; end
                if (key_release[k]) begin n_rel[k]++;   if (e_rel[k]   < 0) e_rel[k]   = edge_no; end
                if (key_long[k])    begin n_long[k]++;  if (e_long[k]  < 0) e_long[k]  = edge_no; end
                if (key_level[k] && !prev_lvl[k]) begin n_rise[k]++; if (e_rise[k] < 0) e_rise[k] = edge_no; end
                if (!key_level[k] && prev_lvl[k]) begin n_fall[k]++; if (e_fall[k] < 0) e_fall[k] = edge_no; end
            end
            prev_lvl = key_level;
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [1:0] kn;
        int         cycles;
        logic [1:0] e_press;
        logic [1:0] e_rel;
        logic [1:0] e_long;
        logic [1:0] e_level;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int rand_cycles;
        int len;

        tbl[0] = '{2'b11,   20, 2'b00, 2'b00, 2'b00, 2'b00};
        tbl[1] = '{2'b10, 3000, 2'b01, 2'b00, 2'b00, 2'b01};
        tbl[2] = '{2'b11, 1500, 2'b00, 2'b01, 2'b00, 2'b00};
        tbl[3] = '{2'b00, 7000, 2'b11, 2'b00, 2'b11, 2'b11};
        tbl[4] = '{2'b11, 1500, 2'b00, 2'b11, 2'b00, 2'b00};
        tbl[5] = '{2'b01, 1200, 2'b10, 2'b00, 2'b00, 2'b10};
        tbl[6] = '{2'b11, 1200, 2'b00, 2'b10, 2'b00, 2'b00};

        rst_n = 1'b0;
        key_n = 2'b11;
        model_reset();
        for (int c = 0; c < 3; c++) tick();
        chk("reset_outputs", int'({key_level, key_press, key_release, key_long}), 0);
        rst_n = 1'b1;

        // table-driven segments
        for (int i = 0; i < 7; i++) begin
            clear_watch();
            key_n = tbl[i].kn;
            watch(tbl[i].cycles);
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("tbl%0d_press%0d", i, k),   n_press[k], int'(tbl[i].e_press[k]));
                chk($sformatf("tbl%0d_release%0d", i, k), n_rel[k],   int'(tbl[i].e_rel[k]));
                chk($sformatf("tbl%0d_long%0d", i, k),    n_long[k],  int'(tbl[i].e_long[k]));
                chk($sformatf("tbl%0d_level%0d", i, k),   int'(key_level[k]), int'(tbl[i].e_level[k]));
            end
        end

        // clean press: exact latency, other channel silent
        clear_watch();
        key_n = 2'b10;
        watch(3000);
        chk("clean_press_edge", e_press[0], DB_CYC + 3);
        chk("clean_press_count", n_press[0], 1);
        chk("clean_level_rise", e_rise[0], DB_CYC + 3);
        chk("clean_other_key", n_press[1] + n_rel[1] + n_long[1] + n_rise[1], 0);
        key_n = 2'b11;
        clear_watch();
        watch(1200);
        chk("clean_release_edge", e_rel[0], DB_CYC + 3);

        // bounce: toggling every 200 cycles never survives the filter
        clear_watch();
        for (int t = 0; t < 15; t++) begin
            key_n = (t % 2 == 0) ? 2'b10 : 2'b11;
            watch(200);
        end
        key_n = 2'b11;
        watch(1200);
        chk("bounce_pulses", n_press[0] + n_rel[0] + n_long[0], 0);
        chk("bounce_level", n_rise[0], 0);

        // long press
        clear_watch();
        key_n = 2'b10;
        watch(7000);
        key_n = 2'b11;
        watch(1200);
        chk("long_press_edge", e_press[0], DB_CYC + 3);
        chk("long_edge", e_long[0], DB_CYC + 3 + LONG_CYC);
        chk("long_count", n_long[0], 1);
        chk("long_release_edge", e_rel[0], 7000 + DB_CYC + 3);
        chk("long_level_fall", e_fall[0], 7000 + DB_CYC + 3);

        // release glitch: 100 high cycles while pressed. The hold count pauses
        // for the glitch plus the return edge, so the long pulse slips by ~100.
        clear_watch();
        key_n = 2'b10;
        watch(2000);
        key_n = 2'b11;
        watch(100);
        key_n = 2'b10;
        watch(4500);
        key_n = 2'b11;
        watch(1200);
        chk("glitch_press_count", n_press[0], 1);
        chk("glitch_first_release", e_rel[0], 6600 + DB_CYC + 3);
        chk("glitch_level_falls", n_fall[0], 1);
        chk("glitch_long_count", n_long[0], 1);
        chk("glitch_long_time",
            int'(e_long[0] >= DB_CYC + 3 + LONG_CYC + 100 && e_long[0] <= DB_CYC + 3 + LONG_CYC + 101), 1);

        // simultaneous presses
        clear_watch();
        key_n = 2'b00;
        watch(1200);
        chk("simul_press0", e_press[0], DB_CYC + 3);
        chk("simul_press1", e_press[1], DB_CYC + 3);
        chk("simul_counts", n_press[0] + n_press[1], 2);
        clear_watch();
        key_n = 2'b11;
        watch(1200);
        chk("simul_release0", e_rel[0], DB_CYC + 3);
        chk("simul_release1", e_rel[1], DB_CYC + 3);

        // async reset while held
        clear_watch();
        key_n = 2'b10;
        watch(1500);
        chk("rst_pre_level", int'(key_level[0]), 1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_immediate", int'({key_level, key_press, key_release, key_long}), 0);
        clear_watch();
        watch(5);
        chk("rst_no_release", n_rel[0], 0);
        rst_n = 1'b1;
        clear_watch();
        watch(1200);
        chk("rst_repress_edge", e_press[0], DB_CYC + 3);
        chk("rst_no_release_after", n_rel[0], 0);
        key_n = 2'b11;
        watch(1200);

        // randomized stimulus against the model
        rand_cycles = 0;
        while (rand_cycles < 30000) begin
            key_n = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       len = $urandom_range(1, 300);
                1, 2:    len = $urandom_range(1000, 2500);
                default: len = $urandom_range(5200, 6500);
            endcase
            watch(len);
            rand_cycles += len;
        end
        key_n = 2'b11;
        watch(1200);
        chk("final_idle_level", int'(key_level), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
